// File: rtl/word_serializer_pkg.sv
// Shared constants for the word serializer: state encoding and default word width.
package word_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10
  } state_t;

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial converter, MSB first, feeding the downstream sequence detector.
// Define WORD_SERIALIZER_PARITY_EN to append one even-parity bit after each word.
//
// state  | meaning
// IDLE   | no word in flight, ready for a new word
// SHIFT  | data bits on x_out, counter walks WIDTH-1 down to 0
// PARITY | parity bit on x_out (only with WORD_SERIALIZER_PARITY_EN)
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  // The MSB goes straight to x_out on accept, so only the remaining bits are held here.
  logic [WIDTH-2:0] shreg_q;
  logic             accept;
  logic             last_bit;
`ifdef WORD_SERIALIZER_PARITY_EN
  logic             par_q;
`endif

  assign last_bit = (state_q == SHIFT) && (cnt_q == '0);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
`ifdef WORD_SERIALIZER_PARITY_EN
    in_ready = (state_q == IDLE) || (state_q == PARITY);
`else
    in_ready = (state_q == IDLE) || last_bit;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == '0) begin
`ifdef WORD_SERIALIZER_PARITY_EN
          state_d = PARITY;
`else
          state_d = in_valid ? SHIFT : IDLE;
`endif
        end
      end
`ifdef WORD_SERIALIZER_PARITY_EN
      PARITY: begin
        state_d = in_valid ? SHIFT : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      shreg_q <= '0;
`ifdef WORD_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (accept) begin
      cnt_q   <= CNT_MAX;
      shreg_q <= in_data[WIDTH-2:0];
`ifdef WORD_SERIALIZER_PARITY_EN
      par_q   <= ^in_data;
`endif
    end else if ((state_q == SHIFT) && (cnt_q != '0)) begin
      cnt_q   <= cnt_q - CW'(1);
      shreg_q <= shreg_q << 1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_out   <= 1'b0;
      x_valid <= 1'b0;
    end else if (accept) begin
      x_out   <= in_data[WIDTH-1];
      x_valid <= 1'b1;
    end else if ((state_q == SHIFT) && (cnt_q != '0)) begin
      x_out   <= shreg_q[WIDTH-2];
      x_valid <= 1'b1;
`ifdef WORD_SERIALIZER_PARITY_EN
    end else if (last_bit) begin
      x_out   <= par_q;
      x_valid <= 1'b1;
`endif
    end else begin
      x_out   <= 1'b0;
      x_valid <= 1'b0;
    end
  end

endmodule
